// File: rtl/alu_multicycle_if.sv
// rtl/alu_multicycle_if.sv - request/response handshake bundle for the multicycle ALU
interface alu_multicycle_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    modport master (
        output in_valid,
        input  in_ready,
        output alu_control,
        output a,
        output b,
        input  out_valid,
        output out_ready,
        input  result,
        input  zero,
        input  illegal
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  alu_control,
        input  a,
        input  b,
        output out_valid,
        input  out_ready,
        output result,
        output zero,
        output illegal
    );
endinterface

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - execute-stage ALU with single-cycle ops and bit-serial shifts
module alu_multicycle (
    input  logic              clk,
    input  logic              rst,
    alu_multicycle_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_SLL = 2'd0,
        K_SRL = 2'd1,
        K_SRA = 2'd2
    } shift_kind_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    state_t      state_q,   state_d;
    shift_kind_t kind_q,    kind_d;
    logic [31:0] work_q,    work_d;
    logic [4:0]  cnt_q,     cnt_d;
    logic [31:0] result_q,  result_d;
    logic        zero_q,    zero_d;
    logic        illegal_q, illegal_d;

    logic [31:0] comb_result;
    logic        comb_illegal;
    logic        is_shift;
    shift_kind_t req_kind;
    logic [31:0] work_shifted;

    // Single-cycle datapath; unsupported codes report illegal with a zero result.
    always_comb begin
        comb_result  = 32'd0;
        comb_illegal = 1'b0;
        case (bus.alu_control)
            OP_AND:  comb_result = bus.a & bus.b;
            OP_OR:   comb_result = bus.a | bus.b;
            OP_ADD:  comb_result = bus.a + bus.b;
            OP_SUB:  comb_result = bus.a - bus.b;
            OP_SLT:  comb_result = {31'd0, $signed(bus.a) < $signed(bus.b)};
            OP_NOR:  comb_result = ~(bus.a | bus.b);
            OP_SLL, OP_SRL, OP_SRA: comb_result = 32'd0;
            default: comb_illegal = 1'b1;
        endcase
    end

    always_comb begin
        is_shift = 1'b0;
        req_kind = K_SLL;
        case (bus.alu_control)
            OP_SLL:  begin is_shift = 1'b1; req_kind = K_SLL; end
            OP_SRL:  begin is_shift = 1'b1; req_kind = K_SRL; end
            OP_SRA:  begin is_shift = 1'b1; req_kind = K_SRA; end
            default: begin is_shift = 1'b0; req_kind = K_SLL; end
        endcase
    end

    // One-bit step of the iterative shifter.
    always_comb begin
        case (kind_q)
            K_SLL:   work_shifted = {work_q[30:0], 1'b0};
            K_SRL:   work_shifted = {1'b0, work_q[31:1]};
            K_SRA:   work_shifted = {work_q[31], work_q[31:1]};
            default: work_shifted = work_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (is_shift) begin
                        work_d = bus.a;
                        cnt_d  = bus.b[4:0];
                        kind_d = req_kind;
                        if (bus.b[4:0] != 5'd0) begin
                            state_d = S_SHIFT;
                        end else begin
                            result_d  = bus.a;
                            zero_d    = (bus.a == 32'd0);
                            illegal_d = 1'b0;
                            state_d   = S_DONE;
                        end
                    end else begin
                        result_d  = comb_result;
                        zero_d    = (comb_result == 32'd0);
                        illegal_d = comb_illegal;
                        state_d   = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                work_d = work_shifted;
                cnt_d  = cnt_q - 5'd1;
                // The last step registers the shifted value directly.
                if (cnt_q == 5'd1) begin
                    result_d  = work_shifted;
                    zero_d    = (work_shifted == 32'd0);
                    illegal_d = 1'b0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            kind_q    <= K_SLL;
            work_q    <= 32'd0;
            cnt_q     <= 5'd0;
            result_q  <= 32'd0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - self-checking bench for alu_multicycle
module tb_alu_multicycle;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    alu_multicycle_if bus_if ();

    alu_multicycle dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_result;
        logic        exp_zero;
        logic        exp_illegal;
        int          exp_lat;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Behavioural reference: plain arithmetic on the operation code.
    function automatic void ref_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] r, output logic ill, output int lat);
        int amt;
        amt = int'(y[4:0]);
        ill = 1'b0;
        lat = 1;
        case (c)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: r = x + y;
            4'b0110: r = x - y;
            4'b0111: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b1100: r = ~(x | y);
            4'b0011: begin r = x << amt;  lat = (amt == 0) ? 1 : amt + 1; end
            4'b0100: begin r = x >> amt;  lat = (amt == 0) ? 1 : amt + 1; end
            4'b0101: begin r = 32'($signed(x) >>> amt); lat = (amt == 0) ? 1 : amt + 1; end
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
    endfunction

    task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] er, input logic ez,
                          input logic eill, input int elat, input int stall);
        int lat;
        @(negedge clk);
        chk({name, " in_ready_idle"}, {31'd0, bus_if.in_ready}, 32'd1);
        bus_if.alu_control = c;
        bus_if.a           = x;
        bus_if.b           = y;
        bus_if.in_valid    = 1'b1;
        bus_if.out_ready   = (stall == 0);
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                bus_if.in_valid    = 1'b0;
                bus_if.a           = $urandom;
                bus_if.b           = $urandom;
                bus_if.alu_control = 4'($urandom);
            end
            if (!bus_if.out_valid)
                chk({name, " in_ready_busy"}, {31'd0, bus_if.in_ready}, 32'd0);
        end while (!bus_if.out_valid && lat < 100);
        if (!bus_if.out_valid) begin
            chk({name, " timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({name, " latency"}, 32'(lat), 32'(elat));
        chk({name, " result"}, bus_if.result, er);
        chk({name, " zero"}, {31'd0, bus_if.zero}, {31'd0, ez});
        chk({name, " illegal"}, {31'd0, bus_if.illegal}, {31'd0, eill});
        chk({name, " in_ready_done"}, {31'd0, bus_if.in_ready}, 32'd0);
        repeat (stall) begin
            @(negedge clk);
            bus_if.in_valid = $urandom_range(0, 1);
            chk({name, " held_valid"}, {31'd0, bus_if.out_valid}, 32'd1);
            chk({name, " held_result"}, bus_if.result, er);
            chk({name, " held_zero"}, {31'd0, bus_if.zero}, {31'd0, ez});
            chk({name, " held_illegal"}, {31'd0, bus_if.illegal}, {31'd0, eill});
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        chk({name, " in_ready_after"}, {31'd0, bus_if.in_ready}, 32'd1);
        chk({name, " out_valid_after"}, {31'd0, bus_if.out_valid}, 32'd0);
    endtask

    initial begin
        logic [3:0]  c;
        logic [31:0] x, y, er;
        logic        eill;
        int          elat;
        logic [3:0]  codes[10];

        checks   = 0;
        failures = 0;

        vecs[0]  = '{"add",       4'b0010, 32'd7,        32'd5,        32'd12,       1'b0, 1'b0, 1};
        vecs[1]  = '{"sub_zero",  4'b0110, 32'd5,        32'd5,        32'd0,        1'b1, 1'b0, 1};
        vecs[2]  = '{"add_wrap",  4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1};
        vecs[3]  = '{"slt_neg",   4'b0111, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1};
        vecs[4]  = '{"nor",       4'b1100, 32'd0,        32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b0, 1};
        vecs[5]  = '{"sra4",      4'b0101, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b0, 5};
        vecs[6]  = '{"sll0",      4'b0011, 32'h12345678, 32'h20,       32'h12345678, 1'b0, 1'b0, 1};
        vecs[7]  = '{"srl31",     4'b0100, 32'h80000000, 32'd31,       32'd1,        1'b0, 1'b0, 32};
        vecs[8]  = '{"and",       4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1};
        vecs[9]  = '{"or",        4'b0001, 32'h0F000000, 32'h000000F0, 32'h0F0000F0, 1'b0, 1'b0, 1};
        vecs[10] = '{"slt_pos",   4'b0111, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 1};
        vecs[11] = '{"ill_1111",  4'b1111, 32'd3,        32'd4,        32'd0,        1'b1, 1'b1, 1};
        vecs[12] = '{"ill_1000",  4'b1000, 32'd5,        32'd9,        32'd0,        1'b1, 1'b1, 1};
        vecs[13] = '{"sll31",     4'b0011, 32'd1,        32'd31,       32'h80000000, 1'b0, 1'b0, 32};
        vecs[14] = '{"srl4",      4'b0100, 32'h000000F0, 32'd4,        32'h0000000F, 1'b0, 1'b0, 5};

        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                  4'b1100, 4'b0011, 4'b0100, 4'b0101, 4'b1111};

        rst                = 1'b1;
        bus_if.in_valid    = 1'b0;
        bus_if.out_ready   = 1'b1;
        bus_if.alu_control = 4'd0;
        bus_if.a           = 32'd0;
        bus_if.b           = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset in_ready",  {31'd0, bus_if.in_ready},  32'd1);
        chk("reset out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        chk("reset result",    bus_if.result,             32'd0);
        chk("reset zero",      {31'd0, bus_if.zero},      32'd0);
        chk("reset illegal",   {31'd0, bus_if.illegal},   32'd0);

        for (int i = 0; i < 15; i++)
            run_op(vecs[i].name, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp_result,
                   vecs[i].exp_zero, vecs[i].exp_illegal, vecs[i].exp_lat, 0);

        // Illegal op held under backpressure while inputs churn.
        run_op("bp_illegal", 4'b1111, 32'hDEADBEEF, 32'h1234, 32'd0, 1'b1, 1'b1, 1, 3);

        // Reset in the middle of a 10-bit shift, then a normal ADD.
        @(negedge clk);
        bus_if.alu_control = 4'b0011;
        bus_if.a           = 32'h00000003;
        bus_if.b           = 32'd10;
        bus_if.in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst in_ready",  {31'd0, bus_if.in_ready},  32'd1);
        chk("midrst out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        chk("midrst result",    bus_if.result,             32'd0);
        chk("midrst zero",      {31'd0, bus_if.zero},      32'd0);
        repeat (12) begin
            @(negedge clk);
            chk("midrst no_stale_valid", {31'd0, bus_if.out_valid}, 32'd0);
        end
        run_op("post_rst_add", 4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1, 0);

        for (int n = 0; n < 40; n++) begin
            c = codes[$urandom_range(0, 9)];
            x = $urandom;
            y = $urandom;
            if (n % 5 == 0) y = x;
            ref_op(c, x, y, er, eill, elat);
            run_op($sformatf("rand%0d_op%b", n, c), c, x, y, er, (er == 32'd0), eill, elat,
                   $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
